// File: rtl/pcm_to_i2s_tx_if.sv
// PCM sample-pair handshake between the delay/sum path and the I2S transmitter.
interface pcm_to_i2s_tx_if #(
  parameter int unsigned NUMBER_OF_BITS = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUMBER_OF_BITS-1:0] in_left;
  logic [NUMBER_OF_BITS-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/pcm_to_i2s_tx.sv
// PCM pair to I2S transmitter: free-running ws, one-entry holding register,
// one-bit-delayed MSB-first serial data, sticky underrun flag.
// Optional build macro PCM_TX_MONO_SUM_EN sends floor((L+R)/2) in both slots.
module pcm_to_i2s_tx #(
  parameter int unsigned NUMBER_OF_BITS = 8,
  parameter int unsigned SLOT_BITS      = 16
) (
  input  logic             clk,
  input  logic             reset,
  pcm_to_i2s_tx_if.slave   pcm,
  output logic             ws_out,
  output logic             sd_out,
  output logic             frame_start,
  output logic             underrun,
  input  logic             clear_underrun
);

  localparam int unsigned CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE  = CNT_W'(SLOT_BITS - 2);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(NUMBER_OF_BITS);

  logic [CNT_W-1:0]          slot_cnt, slot_cnt_nxt;
  logic                      hold_full, hold_full_nxt;
  logic [NUMBER_OF_BITS-1:0] hold_l, hold_r;
  logic                      started;
  logic [NUMBER_OF_BITS-1:0] act_l, act_r;
  logic [NUMBER_OF_BITS-1:0] load_l, load_r;
  logic [NUMBER_OF_BITS-1:0] src_l, src_r;
  logic [NUMBER_OF_BITS-1:0] sel_word, shifted;
  logic                      frame_load, load_next, xfer;
  logic                      ws_nxt, sd_nxt, ready_nxt, underrun_nxt, underrun_set;
`ifdef PCM_TX_MONO_SUM_EN
  logic [NUMBER_OF_BITS:0]   mono_sum;
`endif

  // Next-state and next-output computation
  always_comb begin
    frame_load    = (slot_cnt == SLOT_LAST) && ws_out;
    load_next     = (slot_cnt == SLOT_PRE) && ws_out;
    xfer          = pcm.in_valid && pcm.in_ready;
    slot_cnt_nxt  = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + CNT_W'(1);
    ws_nxt        = (slot_cnt == SLOT_LAST) ? ~ws_out : ws_out;
    hold_full_nxt = xfer || (hold_full && !frame_load);
    ready_nxt     = !hold_full_nxt || load_next;

    // An empty holding register loads a silent frame
    src_l = hold_full ? hold_l : '0;
    src_r = hold_full ? hold_r : '0;
`ifdef PCM_TX_MONO_SUM_EN
    mono_sum = {src_l[NUMBER_OF_BITS-1], src_l} + {src_r[NUMBER_OF_BITS-1], src_r};
    load_l   = NUMBER_OF_BITS'(mono_sum >> 1);
    load_r   = NUMBER_OF_BITS'(mono_sum >> 1);
`else
    load_l = src_l;
    load_r = src_r;
`endif

    underrun_set = frame_load && !hold_full && started;
    underrun_nxt = underrun_set ? 1'b1 : (clear_underrun ? 1'b0 : underrun);

    // Slot cycle k = slot_cnt+1 shows bit N-k of the slot word (one-bit delay)
    sel_word = ws_out ? act_r : act_l;
    shifted  = sel_word << slot_cnt;
    sd_nxt   = (slot_cnt < DATA_END) ? shifted[NUMBER_OF_BITS-1] : 1'b0;
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt     <= '0;
      ws_out       <= 1'b1;
      sd_out       <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      pcm.in_ready <= 1'b1;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      started      <= 1'b0;
      act_l        <= '0;
      act_r        <= '0;
    end else begin
      slot_cnt     <= slot_cnt_nxt;
      ws_out       <= ws_nxt;
      sd_out       <= sd_nxt;
      frame_start  <= frame_load;
      underrun     <= underrun_nxt;
      pcm.in_ready <= ready_nxt;
      hold_full    <= hold_full_nxt;
      if (xfer) begin
        hold_l  <= pcm.in_left;
        hold_r  <= pcm.in_right;
        started <= 1'b1;
      end
      if (frame_load) begin
        act_l <= load_l;
        act_r <= load_r;
      end
    end
  end

endmodule
